accum_adder_unit: RTL and testbench
===================================

# accum_adder_unit

- Parametrised, clocked successor to the TinyTapeout top-level combinational adder.
- Accepts operand pairs over a valid/ready handshake and performs add, subtract, per-channel accumulate or read-and-clear.
- Returns registered results with overflow flags.
- Sits between the pin-level I/O wrapper and any downstream consumer inside the `tt_um_*` top.

## Interface

Parameters:
- `WIDTH`, 8: operand, accumulator and result width in bits (≥ 2).
- `NUM_CH`, 4: number of independent accumulator channels (1–16).
- `SATURATE`, 1: 1 = clamp on overflow/underflow; 0 = wrap modulo 2^WIDTH.

`CH_W` is a localparam: clog2(`NUM_CH`), minimum 1.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request this cycle.
- `in_mode` input 2: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- `in_ch` input `CH_W`: accumulator channel; used by ACC and CLR only.
- `in_a` input `WIDTH`: operand A, unsigned.
- `in_b` input `WIDTH`: operand B, unsigned; ignored by ACC and CLR.
- `out_valid` output 1: result register holds an unconsumed result.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output `WIDTH`: result.
- `out_ovf` output 1: overflow (ADD/ACC carry) or underflow (SUB borrow) for this result.
- `out_ch` output `CH_W`: echo of `in_ch` for this result.
- `ch_ovf` output `NUM_CH`: per-channel sticky accumulator overflow flags.

## Operation

- **Acceptance:** a request is accepted on a rising edge where `in_valid && in_ready`.
- **Ready:** `in_ready = !out_valid || out_ready`. This is a single-entry output register with pass-through ready, so full throughput is one request per cycle.
- **ADD:**
  - Form the `WIDTH+1`-bit sum `a+b`; `out_ovf` = bit `WIDTH`.
  - `SATURATE=1`: on carry, `out_data` = all ones.
  - `SATURATE=0`: `out_data` = low `WIDTH` bits.
  - Accumulators are untouched.
- **SUB:**
  - Compute `a-b`; `out_ovf` = borrow (`b > a`).
  - `SATURATE=1`: on borrow, `out_data` = 0.
  - `SATURATE=0`: two's-complement wrap.
  - Accumulators are untouched.
- **ACC:**
  - Compute `acc[ch] + a` with the same carry/saturation rules as ADD.
  - `acc[ch]` and `out_data` both take the result.
  - On carry, set `ch_ovf[ch]`; the bit stays set until that channel's CLR or reset.
- **CLR (read-and-clear):**
  - `out_data` = `acc[ch]` before clearing; `out_ovf` = `ch_ovf[ch]` before clearing.
  - Then `acc[ch]` ← 0 and `ch_ovf[ch]` ← 0.
- **Out-of-range `in_ch`** (≥ `NUM_CH`) with ACC/CLR:
  - The request is still accepted and produces a result.
  - `out_data` = 0 and `out_ovf` = 0.
  - No accumulator or flag changes.
- **Accumulator update timing:** updates happen at the acceptance edge, not at output handshake. Back-to-back ACC/CLR to the same channel therefore see the updated value with no hazard.
- **Backpressure:** while `out_valid && !out_ready`, `out_data`, `out_ovf` and `out_ch` hold stable and no request is accepted.
- **Reset** (`rst_n` low, any time, including mid-stall):
  - `out_valid`=0, `out_data`=0, `out_ovf`=0, `out_ch`=0.
  - All `acc` = 0 and `ch_ovf` = 0.
  - `in_ready` = 1 on the first cycle after reset release.
  - A pending unconsumed result is discarded.

## Timing

- **Latency:** exactly 1 cycle. A request accepted at edge N gives `out_valid`=1 with its result after edge N.
- **Simultaneous consume and accept** at the same edge: the new result replaces the old; `out_valid` stays 1.
- **Consume without accept:** `out_valid` falls to 0 after the edge.
- **`ch_ovf`:** updates at the acceptance edge, in the same cycle the corresponding result appears.
- **Combinational paths:**
  - The only input-to-output combinational path is `out_ready` → `in_ready`.
  - All other outputs are registered.

## Test plan

All cases use `WIDTH`=8, `NUM_CH`=4.

- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1 → all outputs 0, `in_ready`=1 after release; then CLR ch0 → `out_data`=0.
- **ADD/SUB saturation** (`SATURATE`=1):
  - ADD 200+100 → `out_data`=255, `out_ovf`=1.
  - ADD 20+30 → 50, `out_ovf`=0.
  - SUB 10−20 → 0, `out_ovf`=1.
- **Wrap mode** (`SATURATE`=0): ADD 200+100 → 44, `out_ovf`=1; SUB 10−20 → 246, `out_ovf`=1.
- **Back-to-back ACC with CLR:**
  - ACC ch2 with a=100, 100, 100 on consecutive cycles with `out_ready`=1 → outputs 100, 200, 255 (saturated), `ch_ovf`[2]=1 after the third.
  - CLR ch2 → `out_data`=255, `out_ovf`=1; then `ch_ovf`[2]=0 and a following ACC ch2 a=5 → 5.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0 and the result is stable throughout.
  - Release → exactly one request accepted per cycle, with no loss or duplication over 16 random requests checked against a scoreboard.
- **Channel isolation:**
  - ACC ch0 a=7, then ACC ch3 a=9, then CLR ch0 → 7, then CLR ch3 → 9.
  - A `NUM_CH`=3 build with ACC `in_ch`=3 → `out_data`=0, `out_ovf`=0, and no state change.

Source files
------------

// File: rtl/accum_adder_unit.sv
// accum_adder_unit
//   Clocked add / subtract / per-channel accumulate / read-and-clear unit.
//   Requests enter over a valid/ready handshake and results leave from a
//   single-entry registered output stage one cycle later, with a carry or
//   borrow flag. Each accumulator channel keeps a sticky overflow flag.
//
// Parameters
//   WIDTH    operand, accumulator and result width (>= 2)
//   NUM_CH   number of accumulator channels (1..16)
//   SATURATE 1: clamp on overflow/underflow, 0: wrap modulo 2^WIDTH
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request can be accepted this cycle
//   in_mode    00 ADD, 01 SUB, 10 ACC, 11 CLR
//   in_ch      accumulator channel (ACC/CLR only)
//   in_a       operand A, unsigned
//   in_b       operand B, unsigned (ADD/SUB only)
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result
//   out_data   result
//   out_ovf    carry (ADD/ACC), borrow (SUB) or channel flag (CLR)
//   out_ch     echo of in_ch for this result
//   ch_ovf     per-channel sticky accumulator overflow flags

module accum_adder_unit #(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_ovf,
  output logic [CH_W-1:0]   out_ch,
  output logic [NUM_CH-1:0] ch_ovf
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam bit SAT = (SATURATE != 0);

  mode_e             mode;
  logic              accept;

  logic [WIDTH-1:0]  acc_q [NUM_CH];
  logic [NUM_CH-1:0] ch_ovf_q;

  logic [NUM_CH-1:0] ch_sel;
  logic              ch_hit;
  logic [WIDTH-1:0]  sel_acc;
  logic              sel_ovf;

  logic [WIDTH-1:0]  add_rhs;
  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    sub_diff;

  logic [WIDTH-1:0]  res_data;
  logic              res_ovf;

  assign mode     = mode_e'(in_mode);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ch_ovf   = ch_ovf_q;

  // One-hot channel decode. An out-of-range channel decodes to all zeros,
  // which makes the read mux return zero and suppresses every state update.
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = (in_ch == CH_W'(i));
    end
  end

  assign ch_hit = |ch_sel;

  always_comb begin
    sel_acc = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) begin
        sel_acc = acc_q[i];
        sel_ovf = ch_ovf_q[i];
      end
    end
  end

  // ADD and ACC share one adder: ACC adds operand A to the selected
  // accumulator instead of operand B.
  assign add_rhs  = (mode == MODE_ACC) ? sel_acc : in_b;
  assign add_sum  = {1'b0, in_a} + {1'b0, add_rhs};
  assign sub_diff = {1'b0, in_a} - {1'b0, in_b};

  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    case (mode)
      MODE_ADD: begin
        res_ovf  = add_sum[WIDTH];
        res_data = (SAT && add_sum[WIDTH]) ? '1 : add_sum[WIDTH-1:0];
      end
      MODE_SUB: begin
        // The extra MSB of the widened difference is the borrow.
        res_ovf  = sub_diff[WIDTH];
        res_data = (SAT && sub_diff[WIDTH]) ? '0 : sub_diff[WIDTH-1:0];
      end
      MODE_ACC: begin
        if (ch_hit) begin
          res_ovf  = add_sum[WIDTH];
          res_data = (SAT && add_sum[WIDTH]) ? '1 : add_sum[WIDTH-1:0];
        end
      end
      MODE_CLR: begin
        if (ch_hit) begin
          res_ovf  = sel_ovf;
          res_data = sel_acc;
        end
      end
      default: begin
        res_data = '0;
        res_ovf  = 1'b0;
      end
    endcase
  end

  // Single-entry output register; a new acceptance overwrites the slot in
  // the same edge the old result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_ovf   <= res_ovf;
      out_ch    <= in_ch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator state moves at acceptance, so a back-to-back request to
  // the same channel reads the already-updated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      ch_ovf_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel[i]) begin
          if (mode == MODE_ACC) begin
            acc_q[i] <= res_data;
            if (res_ovf) begin
              ch_ovf_q[i] <= 1'b1;
            end
          end else if (mode == MODE_CLR) begin
            acc_q[i]    <= '0;
            ch_ovf_q[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_adder_unit.sv
module tb_accum_adder_unit;

  localparam int MAXV = 255;
  localparam int NINST = 3;
  // instance 0: saturating 4 ch, 1: wrapping 4 ch, 2: saturating 3 ch
  localparam int SAT_OF [NINST] = '{1, 0, 1};
  localparam int NCH_OF [NINST] = '{4, 4, 3};

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_mode;
  logic [1:0] in_ch;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_ready;

  logic       rdy   [NINST];
  logic       vld   [NINST];
  logic [7:0] dat   [NINST];
  logic       ovf   [NINST];
  logic [1:0] och   [NINST];
  logic [3:0] chovf [2];
  logic [2:0] chovf_n3;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accepts = 0;

  // model state
  int m_acc   [NINST][4];
  bit m_flag  [NINST][4];
  bit e_valid [NINST];
  int e_data  [NINST];
  bit e_ovf   [NINST];
  int e_ch    [NINST];

  accum_adder_unit #(.WIDTH(8), .NUM_CH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_mode(in_mode), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(vld[0]), .out_ready(out_ready), .out_data(dat[0]),
    .out_ovf(ovf[0]), .out_ch(och[0]), .ch_ovf(chovf[0])
  );

  accum_adder_unit #(.WIDTH(8), .NUM_CH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_mode(in_mode), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(vld[1]), .out_ready(out_ready), .out_data(dat[1]),
    .out_ovf(ovf[1]), .out_ch(och[1]), .ch_ovf(chovf[1])
  );

  accum_adder_unit #(.WIDTH(8), .NUM_CH(3), .SATURATE(1)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_mode(in_mode), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(vld[2]), .out_ready(out_ready), .out_data(dat[2]),
    .out_ovf(ovf[2]), .out_ch(och[2]), .ch_ovf(chovf_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int k, input int d, input int o);
    check($sformatf("%s_data[%0d]", name, k), dat[k], d);
    check($sformatf("%s_ovf[%0d]", name, k), ovf[k], o);
  endtask

  // Behavioural reference: arithmetic on plain integers, one slot per DUT.
  always @(posedge clk or negedge rst_n) begin
    bit take;
    int r;
    bit ov;
    int c;
    if (!rst_n) begin
      for (int k = 0; k < NINST; k++) begin
        e_valid[k] = 0; e_data[k] = 0; e_ovf[k] = 0; e_ch[k] = 0;
        for (int j = 0; j < 4; j++) begin
          m_acc[k][j] = 0; m_flag[k][j] = 0;
        end
      end
    end else begin
      for (int k = 0; k < NINST; k++) begin
        take = in_valid && (!e_valid[k] || out_ready);
        if (take) begin
          c  = int'(in_ch);
          r  = 0;
          ov = 0;
          case (in_mode)
            M_ADD: begin
              r = int'(in_a) + int'(in_b);
              ov = (r > MAXV);
              if (ov) r = (SAT_OF[k] != 0) ? MAXV : r - (MAXV + 1);
            end
            M_SUB: begin
              r = int'(in_a) - int'(in_b);
              ov = (r < 0);
              if (ov) r = (SAT_OF[k] != 0) ? 0 : r + (MAXV + 1);
            end
            M_ACC: begin
              if (c < NCH_OF[k]) begin
                r = m_acc[k][c] + int'(in_a);
                ov = (r > MAXV);
                if (ov) r = (SAT_OF[k] != 0) ? MAXV : r - (MAXV + 1);
                m_acc[k][c] = r;
                if (ov) m_flag[k][c] = 1;
              end
            end
            default: begin
              if (c < NCH_OF[k]) begin
                r = m_acc[k][c];
                ov = m_flag[k][c];
                m_acc[k][c] = 0;
                m_flag[k][c] = 0;
              end
            end
          endcase
          e_valid[k] = 1; e_data[k] = r; e_ovf[k] = ov; e_ch[k] = c;
          if (k == 0) n_accepts++;
        end else if (out_ready) begin
          e_valid[k] = 0;
        end
      end
    end
  end

  // Compare every DUT against the model on every falling edge.
  always @(negedge clk) begin
    int exp_flags;
    int act_flags;
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("in_ready[%0d]", k), rdy[k], int'(!e_valid[k] || out_ready));
      check($sformatf("out_valid[%0d]", k), vld[k], int'(e_valid[k]));
      if (e_valid[k] || !rst_n) begin
        check($sformatf("out_data[%0d]", k), dat[k], e_data[k]);
        check($sformatf("out_ovf[%0d]", k), ovf[k], int'(e_ovf[k]));
        check($sformatf("out_ch[%0d]", k), och[k], e_ch[k]);
      end
      exp_flags = 0;
      for (int j = 0; j < NCH_OF[k]; j++) exp_flags |= int'(m_flag[k][j]) << j;
      if (k < 2) act_flags = int'(chovf[k]);
      else       act_flags = int'(chovf_n3);
      check($sformatf("ch_ovf[%0d]", k), act_flags, exp_flags);
    end
  end

  task automatic drive(input logic [1:0] m, input logic [1:0] c, input logic [7:0] a,
                       input logic [7:0] b);
    in_valid = 1'b1; in_mode = m; in_ch = c; in_a = a; in_b = b;
  endtask

  // One request with out_ready held high; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [1:0] c, input logic [7:0] a,
                      input logic [7:0] b);
    int guard;
    drive(m, c, a, b);
    #1;
    guard = 0;
    while (!rdy[0] && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    check("send_ready", rdy[0], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int guard;
    int start_acc;
    rst_n = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_ch = 2'b00;
    in_a = 8'd0; in_b = 8'd0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("init_in_ready", rdy[0], 1);
    check("init_out_valid", vld[0], 0);

    // saturating vs wrapping arithmetic
    send(M_ADD, 2'd0, 8'd200, 8'd100);
    check_out("add_carry", 0, 255, 1);
    check_out("add_carry", 1, 44, 1);
    check("model_pin_add", e_data[0], 255);
    send(M_ADD, 2'd0, 8'd20, 8'd30);
    check_out("add_plain", 0, 50, 0);
    check_out("add_plain", 1, 50, 0);
    send(M_SUB, 2'd0, 8'd10, 8'd20);
    check_out("sub_borrow", 0, 0, 1);
    check_out("sub_borrow", 1, 246, 1);
    check("model_pin_sub", e_data[1], 246);

    // back-to-back accumulate, then read-and-clear
    send(M_ACC, 2'd2, 8'd100, 8'd0);
    check_out("acc1", 0, 100, 0);
    send(M_ACC, 2'd2, 8'd100, 8'd0);
    check_out("acc2", 0, 200, 0);
    send(M_ACC, 2'd2, 8'd100, 8'd0);
    check_out("acc3", 0, 255, 1);
    check_out("acc3", 1, 44, 1);
    check("acc3_chovf2", chovf[0][2], 1);
    send(M_CLR, 2'd2, 8'd0, 8'd0);
    check_out("clr2", 0, 255, 1);
    check_out("clr2", 1, 44, 1);
    check("clr2_chovf2", chovf[0][2], 0);
    send(M_ACC, 2'd2, 8'd5, 8'd0);
    check_out("acc_after_clr", 0, 5, 0);

    // channel isolation and out-of-range channel on the 3-channel build
    send(M_ACC, 2'd0, 8'd7, 8'd0);
    check_out("iso_acc0", 0, 7, 0);
    send(M_ACC, 2'd3, 8'd9, 8'd0);
    check_out("iso_acc3", 0, 9, 0);
    check_out("oor_acc3", 2, 0, 0);
    send(M_CLR, 2'd0, 8'd0, 8'd0);
    check_out("iso_clr0", 0, 7, 0);
    check_out("iso_clr0", 2, 7, 0);
    send(M_CLR, 2'd3, 8'd0, 8'd0);
    check_out("iso_clr3", 0, 9, 0);
    check_out("oor_clr3", 2, 0, 0);
    check("oor_chovf", chovf_n3, 0);

    // backpressure: result stable, no acceptance while stalled
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(M_ADD, 2'd1, 8'd20, 8'd30);
    @(posedge clk); #1;
    check("bp_first_valid", vld[0], 1);
    drive(M_SUB, 2'd2, 8'd50, 8'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_in_ready", rdy[0], 0);
      check("bp_hold_data", dat[0], 50);
      check("bp_hold_ch", och[0], 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", rdy[0], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("bp_next", 0, 49, 0);
    check("bp_next_ch", och[0], 2);

    // random traffic with random backpressure; model checks every cycle
    start_acc = n_accepts;
    for (int n = 0; n < 16; n++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      guard = 0;
      while (!rdy[0] && guard < 50) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        guard++;
      end
      check("rand_ready", rdy[0], 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rand_accept_count", n_accepts - start_acc, 16);

    // reset while a result is stalled
    out_ready = 1'b0;
    drive(M_ADD, 2'd3, 8'd1, 8'd2);
    @(posedge clk); #1;
    check("stall_valid", vld[0], 1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", vld[0], 0);
    check("rst_out_data", dat[0], 0);
    check("rst_out_ovf", ovf[0], 0);
    check("rst_out_ch", och[0], 0);
    check("rst_ch_ovf", chovf[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", rdy[0], 1);
    out_ready = 1'b1;
    send(M_CLR, 2'd0, 8'd0, 8'd0);
    check_out("rst_clr0", 0, 0, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
